rot_pipe: RTL and testbench
===========================

# rot_pipe

Pipelined, handshaked successor to the combinational barrel rotator. Rotates or shifts an N-bit word (N = 2^LOG2_N) by a LOG2_N-bit amount, in one of four modes. Pipeline registers are inserted after every STAGES_PER_REG mux stages, and the pipeline accepts one operation per cycle under valid/ready flow control. It sits between a producer and consumer that both use valid/ready streaming.

## Interface
- N, 256, data width in bits; must equal 1 << LOG2_N.
- LOG2_N, 8, number of mux stages; also the width of the shift amount.
- STAGES_PER_REG, 2, mux stages between pipeline registers; legal range 1..LOG2_N.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  an operation is offered.
- in_ready  output  1  the block accepts the operation this cycle.
- in_data  input  [0:N-1]  operand; bit 0 is the MSB.
- in_k  input  [0:LOG2_N-1]  shift amount; in_k[0] has weight N/2.
- in_mode  input  2  operation, encoded as rot_mode_t.
- out_valid  output  1  a result is presented.
- out_ready  input  1  the consumer takes the result this cycle.
- out_data  output  [0:N-1]  result; bit 0 is the MSB.
- done_count  output  32  completed-operation counter; present only with ROT_PIPE_CNT_EN.

## Operation
- Amount: K = unsigned value of in_k, in the range 0..N-1. Output index i is in 0..N-1.
- Modes:
  - ROTR (2'b00): out[i] = in[(i-K) mod N].
  - ROTL (2'b01): out[i] = in[(i+K) mod N].
  - SHR (2'b10): out[i] = in[i-K] for i ≥ K, else 0.
  - SRA (2'b11): out[i] = in[i-K] for i ≥ K, else in[0].
- K=0 returns in_data unchanged in every mode.
- Mux stage s (0..LOG2_N-1) applies a move of N >> (s+1) when k[s]=1.
- Mode and the remaining k bits travel with the data through every pipeline register.
- Number of pipeline registers: L = ceil(LOG2_N / STAGES_PER_REG). The last register drives out_data and out_valid directly; there is no combinational path from input data to output data.
- Flow control is per register with bubble collapse:
  - Register j loads when its valid bit v[j] = 0 or register j+1 can load. For the last register, "register j+1 can load" means out_ready.
  - in_ready = load condition of register 0.
  - out_valid = v[L-1].
  - Transfers happen on valid && ready in the same cycle.
- While out_valid=1 && out_ready=0, out_data is held stable.
- Results leave in acceptance order. No operation is ever dropped or duplicated.
- Parameter check: N != 1 << LOG2_N, or STAGES_PER_REG outside 1..LOG2_N, is an elaboration-time fatal error.

## Timing
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+L-1, so it is visible in the cycle following edge t+L-1. That is L cycles from acceptance to presentation.
- Throughput: one operation per cycle while out_ready=1.
- Capacity: L operations. With out_ready held low, in_ready falls once all L registers are valid.
- Simultaneous accept and emit when full: with out_ready=1, in_ready=1 in the same cycle, so the pipeline stays full without a bubble.
- Reset values: all v[j]=0, out_valid=0, out_data=0, done_count=0. in_ready is 1 one cycle after rst deasserts.
- Reset mid-operation: in-flight operations are discarded. No out_valid pulse occurs after rst until a new operation is accepted.
- in_ready depends combinationally on out_ready through the register chain. It does not depend on in_valid.

## Configuration
- ROT_PIPE_CNT_EN defined:
  - done_count port exists and increments by 1 on every cycle with out_valid && out_ready.
  - Wraps from 2^32-1 to 0.
  - Cleared by rst.
- ROT_PIPE_CNT_EN undefined: no done_count port and no counter logic. Datapath behaviour is otherwise identical.

## Structure
- Package rot_pkg holds:
  - typedef rot_mode_t as a 2-bit enum: ROT_R, ROT_L, SHR, SRA.
  - function clog2-style ceiling division used to compute L.
- Sub-module rot_pipe_stage: one combinational mux stage with parameters N and STAGE, and inputs data, k bit, and mode. rot_pipe generates LOG2_N instances of it, with pipeline registers between groups of STAGES_PER_REG instances.

## Test plan
- N=8, LOG2_N=3, STAGES_PER_REG=1 (L=3), out_ready=1:
  - in 1000_0001, ROTR, K=1 → 1100_0000, out_valid exactly 3 cycles after acceptance.
  - in 1000_0001, ROTL, K=1 → 0000_0011.
  - in 1001_0110, SHR, K=3 → 0001_0010.
  - in 1001_0110, SRA, K=3 → 1111_0010.
  - K=0 in each mode returns the input unchanged.
- Back-to-back stream, 8 operations on consecutive cycles with random modes and amounts → 8 results on consecutive cycles, in order, matching the reference model.
- Backpressure: out_ready=0, offer 4 operations → in_ready drops after 3 accepts and out_data is stable. Then set out_ready=1 → all 4 results emerge in order; done_count=4 with ROT_PIPE_CNT_EN.
- Full-pipe simultaneity: pipeline full, in_valid=1 and out_ready=1 held for 5 cycles → 5 accepts and 5 emits, in_ready never 0.
- Reset mid-flight: accept 2 operations, assert rst for 1 cycle → out_valid=0, out_data=0, done_count=0, and no stale result appears afterwards.
- STAGES_PER_REG=LOG2_N=8, N=256 (L=1) → single-cycle latency; random ROTR/ROTL/SHR/SRA results match the model.

Source files
------------

// File: rtl/rot_pkg.sv
// rot_pkg: shared types and helpers for the pipelined barrel rotator.
//   rot_mode_t - operation select carried alongside each operand.
//   ceil_div   - ceiling division, used to size the pipeline register chain.
package rot_pkg;

  typedef enum logic [1:0] {
    ROT_R = 2'b00,  // rotate towards higher indices (towards the LSB)
    ROT_L = 2'b01,  // rotate towards lower indices (towards the MSB)
    SHR   = 2'b10,  // logical shift, zero fill at the MSB end
    SRA   = 2'b11   // arithmetic shift, bit 0 (MSB) replicated
  } rot_mode_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (b == 0) ? a : (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/rot_pipe_stage.sv
// rot_pipe_stage: one combinational mux stage of the barrel rotator.
// Applies a move of N >> (STAGE+1) positions when k_bit is set, otherwise
// passes data through. Bit 0 of every word is the MSB.
//   data   - stage input word
//   k_bit  - amount bit belonging to this stage
//   mode   - rotate/shift mode
//   result - stage output word
module rot_pipe_stage
  import rot_pkg::*;
#(
  parameter int unsigned N     = 256,
  parameter int unsigned STAGE = 0
) (
  input  logic [0:N-1] data,
  input  logic         k_bit,
  input  rot_mode_t    mode,
  output logic [0:N-1] result
);

  localparam int unsigned MOVE = N >> (STAGE + 1);

  always_comb begin
    result = data;
    if (k_bit) begin
      for (int unsigned i = 0; i < N; i++) begin
        case (mode)
          ROT_R:   result[i] = data[(i + N - MOVE) % N];
          ROT_L:   result[i] = data[(i + MOVE) % N];
          SHR:     result[i] = (i >= MOVE) ? data[i - MOVE] : 1'b0;
          // Bit 0 always falls in the fill region, so the sign survives
          // every stage and chained stages compose into one arithmetic shift.
          default: result[i] = (i >= MOVE) ? data[i - MOVE] : data[0];
        endcase
      end
    end
  end

endmodule

// File: rtl/rot_pipe.sv
// rot_pipe: pipelined, valid/ready handshaked barrel rotator/shifter.
// LOG2_N mux stages, with a pipeline register after every STAGES_PER_REG
// stages (L = ceil(LOG2_N / STAGES_PER_REG) registers). Each register
// carries data, mode and amount, and loads when empty or when its successor
// can load, so bubbles collapse and a full pipe streams at one op per cycle.
// Optional feature: define ROT_PIPE_CNT_EN to add the done_count port.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - operand handshake
//   in_data, in_k       - operand (bit 0 = MSB) and amount (in_k[0] = N/2)
//   in_mode             - operation (rot_mode_t)
//   out_valid/out_ready - result handshake
//   out_data            - result (bit 0 = MSB), registered
//   done_count          - completed transfers, 32-bit wrapping (optional)
module rot_pipe
  import rot_pkg::*;
#(
  parameter int unsigned N              = 256,
  parameter int unsigned LOG2_N         = 8,
  parameter int unsigned STAGES_PER_REG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:N-1]      in_data,
  input  logic [0:LOG2_N-1] in_k,
  input  rot_mode_t         in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:N-1]      out_data
`ifdef ROT_PIPE_CNT_EN
  ,
  output logic [31:0]       done_count
`endif
);

  if (N != (1 << LOG2_N) || STAGES_PER_REG < 1 || STAGES_PER_REG > LOG2_N) begin : g_bad_params
    $fatal(1, "rot_pipe: illegal parameters N=%0d LOG2_N=%0d STAGES_PER_REG=%0d",
           N, LOG2_N, STAGES_PER_REG);
  end

  localparam int unsigned SPR = (STAGES_PER_REG == 0) ? 1 : STAGES_PER_REG;
  localparam int unsigned L   = ceil_div(LOG2_N, SPR);

  // Pipeline registers
  logic [0:L-1]      v_q;
  logic [0:N-1]      data_q [0:L-1];
  logic [0:LOG2_N-1] k_q    [0:L-1];
  rot_mode_t         mode_q [0:L-1];

  // What feeds each register's group of mux stages
  logic [0:L-1]      src_valid;
  logic [0:N-1]      src_data [0:L-1];
  logic [0:LOG2_N-1] src_k    [0:L-1];
  rot_mode_t         src_mode [0:L-1];

  logic [0:N-1]      st_out  [0:LOG2_N-1];
  logic [0:N-1]      grp_out [0:L-1];
  logic [0:L]        load;

  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_k[0]     = in_k;
    src_mode[0]  = in_mode;
    for (int unsigned j = 1; j < L; j++) begin
      src_valid[j] = v_q[j-1];
      src_data[j]  = data_q[j-1];
      src_k[j]     = k_q[j-1];
      src_mode[j]  = mode_q[j-1];
    end
  end

  for (genvar s = 0; s < LOG2_N; s++) begin : g_stage
    localparam int unsigned G = s / SPR;
    logic [0:N-1] stage_in;
    if (s % SPR == 0) begin : g_first
      assign stage_in = src_data[G];
    end else begin : g_chain
      assign stage_in = st_out[s-1];
    end
    rot_pipe_stage #(.N(N), .STAGE(s)) u_stage (
      .data   (stage_in),
      .k_bit  (src_k[G][s]),
      .mode   (src_mode[G]),
      .result (st_out[s])
    );
  end

  for (genvar j = 0; j < L; j++) begin : g_grp
    localparam int unsigned LAST = ((j + 1) * SPR < LOG2_N) ? (j + 1) * SPR - 1 : LOG2_N - 1;
    assign grp_out[j] = st_out[LAST];
  end

  // Ready ripples back from the consumer; an empty register always loads.
  always_comb begin
    load    = '0;
    load[L] = out_ready;
    for (int unsigned j = L; j > 0; j--) begin
      load[j-1] = !v_q[j-1] || load[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned j = 0; j < L; j++) begin
        data_q[j] <= '0;
        k_q[j]    <= '0;
        mode_q[j] <= ROT_R;
      end
    end else begin
      for (int unsigned j = 0; j < L; j++) begin
        if (load[j]) begin
          v_q[j] <= src_valid[j];
          // Payload only moves with a valid op, so out_data stays put across bubbles.
          if (src_valid[j]) begin
            data_q[j] <= grp_out[j];
            k_q[j]    <= src_k[j];
            mode_q[j] <= src_mode[j];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[L-1];
  assign out_data  = data_q[L-1];

`ifdef ROT_PIPE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_count <= '0;
    end else if (out_valid && out_ready) begin
      done_count <= done_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rot_pipe.sv
// tb_rot_pipe: directed self-checking bench for rot_pipe.
// Small instance: N=8, LOG2_N=3, STAGES_PER_REG=1 (three registers).
// Wide instance:  N=256, LOG2_N=8, STAGES_PER_REG=8 (one register).
module tb_rot_pipe;
  import rot_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Small DUT
  logic       s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
  logic [0:7] s_in_data = '0, s_out_data;
  logic [0:2] s_in_k = '0;
  rot_mode_t  s_in_mode = ROT_R;
  // Wide DUT
  logic         w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b1;
  logic [0:255] w_in_data = '0, w_out_data;
  logic [0:7]   w_in_k = '0;
  rot_mode_t    w_in_mode = ROT_R;
`ifdef ROT_PIPE_CNT_EN
  logic [31:0] s_done_count, w_done_count;
`endif

  rot_pipe #(.N(8), .LOG2_N(3), .STAGES_PER_REG(1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_k(s_in_k), .in_mode(s_in_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data)
`ifdef ROT_PIPE_CNT_EN
    , .done_count(s_done_count)
`endif
  );

  rot_pipe #(.N(256), .LOG2_N(8), .STAGES_PER_REG(8)) dut_w (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_k(w_in_k), .in_mode(w_in_mode),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data)
`ifdef ROT_PIPE_CNT_EN
    , .done_count(w_done_count)
`endif
  );

  // Reference: direct per-bit definition of each mode over the first n bits.
  function automatic logic [0:255] ref_model(input logic [0:255] d, input int unsigned n,
                                             input int unsigned k, input rot_mode_t m);
    logic [0:255] r;
    r = '0;
    for (int unsigned i = 0; i < n; i++) begin
      case (m)
        ROT_R:   r[i] = d[(i + n - k) % n];
        ROT_L:   r[i] = d[(i + k) % n];
        SHR:     r[i] = (i >= k) ? d[i - k] : 1'b0;
        default: r[i] = (i >= k) ? d[i - k] : d[0];
      endcase
    end
    return r;
  endfunction

  function automatic logic [0:7] model8(input logic [0:7] d, input int unsigned k, input rot_mode_t m);
    logic [0:255] w;
    w = '0;
    w[0:7] = d;
    w = ref_model(w, 8, k, m);
    return w[0:7];
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    s_in_valid = 1'b0; w_in_valid = 1'b0; s_out_ready = 1'b1; w_out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (s_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", s_out_valid); end
    n_cmp++; if (s_out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h want 00", s_out_data); end
    n_cmp++; if (w_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_w_out_valid: got %b want 0", w_out_valid); end
    n_cmp++; if (w_out_data !== 256'd0) begin n_bad++; $display("FAIL reset_w_out_data: got %h want 0", w_out_data); end
`ifdef ROT_PIPE_CNT_EN
    n_cmp++; if (s_done_count !== 32'd0) begin n_bad++; $display("FAIL reset_done_count: got %0d want 0", s_done_count); end
`endif
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", s_in_ready); end
  endtask

  // One isolated op; checks acceptance, three-cycle latency and the result.
  task automatic run_one(input string name, input logic [0:7] d, input int unsigned k,
                         input rot_mode_t m, input logic [0:7] exp);
    int lat;
    @(negedge clk);
    s_out_ready = 1'b1;
    s_in_valid = 1'b1; s_in_data = d; s_in_k = 3'(k); s_in_mode = m;
    #1;
    n_cmp++; if (s_in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_accept: in_ready %b want 1", name, s_in_ready); end
    @(negedge clk);
    s_in_valid = 1'b0;
    lat = 1;
    while (s_out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL %s_latency: got %0d cycles want 3", name, lat); end
    n_cmp++; if (s_out_data !== exp) begin n_bad++; $display("FAIL %s_data: got %b want %b", name, s_out_data, exp); end
  endtask

  task automatic test_modes();
    run_one("rotr_k1", 8'b1000_0001, 1, ROT_R, 8'b1100_0000);
    run_one("rotl_k1", 8'b1000_0001, 1, ROT_L, 8'b0000_0011);
    run_one("shr_k3",  8'b1001_0110, 3, SHR,   8'b0001_0010);
    run_one("sra_k3",  8'b1001_0110, 3, SRA,   8'b1111_0010);
    run_one("rotr_k0", 8'b1011_0010, 0, ROT_R, 8'b1011_0010);
    run_one("rotl_k0", 8'b1011_0010, 0, ROT_L, 8'b1011_0010);
    run_one("shr_k0",  8'b1011_0010, 0, SHR,   8'b1011_0010);
    run_one("sra_k0",  8'b1011_0010, 0, SRA,   8'b1011_0010);
    run_one("rotl_k7", 8'b1000_0000, 7, ROT_L, 8'b0100_0000);
  endtask

  task automatic test_back_to_back();
    logic [0:7]  bd[8] = '{8'h3c, 8'ha5, 8'h81, 8'hf0, 8'h96, 8'h01, 8'h80, 8'h5a};
    int unsigned bk[8] = '{5, 2, 7, 4, 1, 6, 3, 0};
    rot_mode_t   bm[8] = '{ROT_L, SRA, ROT_R, SHR, SRA, ROT_L, SHR, ROT_R};
    logic [0:7] exp_q[$];
    logic [0:7] e;
    int rcv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      s_out_ready = 1'b1;
      if (c < 8) begin
        s_in_valid = 1'b1; s_in_data = bd[c]; s_in_k = 3'(bk[c]); s_in_mode = bm[c];
      end else begin
        s_in_valid = 1'b0;
      end
      #1;
      if (c < 8) begin
        n_cmp++; if (s_in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, s_in_ready); end
        exp_q.push_back(model8(bd[c], bk[c], bm[c]));
      end
      n_cmp++;
      if (s_out_valid !== ((c >= 3 && c < 11) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL b2b_out_valid[%0d]: got %b want %b", c, s_out_valid, (c >= 3 && c < 11));
      end
      if (s_out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++; if (s_out_data !== e) begin n_bad++; $display("FAIL b2b_data[%0d]: got %b want %b", rcv, s_out_data, e); end
        rcv++;
      end
    end
    n_cmp++; if (rcv != 8) begin n_bad++; $display("FAIL b2b_count: got %0d want 8", rcv); end
  endtask

  task automatic test_backpressure();
    logic [0:7]  bd[4] = '{8'hc3, 8'h18, 8'h7e, 8'h81};
    int unsigned bk[4] = '{1, 6, 3, 5};
    rot_mode_t   bm[4] = '{ROT_R, SRA, ROT_L, SHR};
    logic [0:7] exp_q[$];
    logic [0:7] held, e;
    int acc = 0, rcv = 0, cyc = 0;
    pulse_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      s_out_ready = 1'b0;
      s_in_valid = (acc < 4); s_in_data = bd[acc % 4]; s_in_k = 3'(bk[acc % 4]); s_in_mode = bm[acc % 4];
      #1;
      if (s_in_valid && s_in_ready) begin exp_q.push_back(model8(bd[acc], bk[acc], bm[acc])); acc++; end
      if (c == 3) held = s_out_data;
    end
    n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL bp_accepts: got %0d want 3", acc); end
    n_cmp++; if (s_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", s_in_ready); end
    n_cmp++; if (s_out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b want 1", s_out_valid); end
    n_cmp++; if (s_out_data !== held) begin n_bad++; $display("FAIL bp_stable: got %b want %b", s_out_data, held); end
    while (rcv < 4 && cyc < 20) begin
      @(negedge clk);
      s_out_ready = 1'b1;
      s_in_valid = (acc < 4); s_in_data = bd[acc % 4]; s_in_k = 3'(bk[acc % 4]); s_in_mode = bm[acc % 4];
      #1;
      if (s_in_valid && s_in_ready) begin exp_q.push_back(model8(bd[acc], bk[acc], bm[acc])); acc++; end
      if (s_out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++; if (s_out_data !== e) begin n_bad++; $display("FAIL bp_data[%0d]: got %b want %b", rcv, s_out_data, e); end
        rcv++;
      end
      cyc++;
    end
    n_cmp++; if (rcv != 4) begin n_bad++; $display("FAIL bp_drain: got %0d results want 4", rcv); end
    @(negedge clk);
    s_in_valid = 1'b0;
`ifdef ROT_PIPE_CNT_EN
    n_cmp++; if (s_done_count !== 32'd4) begin n_bad++; $display("FAIL bp_done_count: got %0d want 4", s_done_count); end
`endif
  endtask

  task automatic test_full_simul();
    logic [0:7] exp_q[$];
    logic [0:7] d, e;
    int unsigned k;
    rot_mode_t m;
    int acc = 0, emit = 0, cyc = 0;
    pulse_reset();
    while (acc < 3 && cyc < 10) begin
      @(negedge clk);
      s_out_ready = 1'b0;
      d = 8'(8'h11 * (acc + 1)); k = acc + 2; m = rot_mode_t'(acc % 4);
      s_in_valid = 1'b1; s_in_data = d; s_in_k = 3'(k); s_in_mode = m;
      #1;
      if (s_in_ready) begin exp_q.push_back(model8(d, k, m)); acc++; end
      cyc++;
    end
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      s_out_ready = 1'b1;
      d = 8'(8'h29 + 8'(37 * c)); k = (c * 3 + 1) % 8; m = rot_mode_t'((c + 1) % 4);
      s_in_valid = 1'b1; s_in_data = d; s_in_k = 3'(k); s_in_mode = m;
      #1;
      n_cmp++; if (s_in_ready !== 1'b1) begin n_bad++; $display("FAIL full_in_ready[%0d]: got %b want 1", c, s_in_ready); end
      if (s_in_ready) begin exp_q.push_back(model8(d, k, m)); acc++; end
      if (s_out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++; if (s_out_data !== e) begin n_bad++; $display("FAIL full_data[%0d]: got %b want %b", emit, s_out_data, e); end
        emit++;
      end
    end
    n_cmp++; if (acc != 5) begin n_bad++; $display("FAIL full_accepts: got %0d want 5", acc); end
    n_cmp++; if (emit != 5) begin n_bad++; $display("FAIL full_emits: got %0d want 5", emit); end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 10) begin
      @(negedge clk);
      s_in_valid = 1'b0;
      #1;
      if (s_out_valid === 1'b1) begin
        e = exp_q.pop_front();
        n_cmp++; if (s_out_data !== e) begin n_bad++; $display("FAIL full_drain_data: got %b want %b", s_out_data, e); end
      end
      cyc++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL full_drain: %0d results missing want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    pulse_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      s_out_ready = 1'b1;
      s_in_valid = 1'b1; s_in_data = 8'hff; s_in_k = 3'(c + 1); s_in_mode = ROT_R;
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (s_out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", s_out_valid); end
    n_cmp++; if (s_out_data !== 8'h00) begin n_bad++; $display("FAIL midrst_out_data: got %h want 00", s_out_data); end
`ifdef ROT_PIPE_CNT_EN
    n_cmp++; if (s_done_count !== 32'd0) begin n_bad++; $display("FAIL midrst_done_count: got %0d want 0", s_done_count); end
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (s_out_valid !== 1'b0) stale++;
    end
    n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL midrst_stale: got %0d valid cycles want 0", stale); end
  endtask

  task automatic test_single_reg();
    int unsigned wk[6] = '{37, 200, 1, 255, 128, 0};
    rot_mode_t   wm[6] = '{ROT_R, ROT_L, SHR, SRA, SRA, SHR};
    logic [0:255] exp_q[6];
    logic [0:255] d;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      w_out_ready = 1'b1;
      if (c < 6) begin
        for (int b = 0; b < 8; b++) d[b*32 +: 32] = $urandom();
        if (c == 3) d[0] = 1'b1;  // exercise sign fill
        w_in_valid = 1'b1; w_in_data = d; w_in_k = 8'(wk[c]); w_in_mode = wm[c];
        exp_q[c] = ref_model(d, 256, wk[c], wm[c]);
      end else begin
        w_in_valid = 1'b0;
      end
      #1;
      if (c < 6) begin
        n_cmp++; if (w_in_ready !== 1'b1) begin n_bad++; $display("FAIL l1_in_ready[%0d]: got %b want 1", c, w_in_ready); end
      end
      if (c > 0) begin
        n_cmp++; if (w_out_valid !== 1'b1) begin n_bad++; $display("FAIL l1_out_valid[%0d]: got %b want 1", c - 1, w_out_valid); end
        n_cmp++; if (w_out_data !== exp_q[c-1]) begin n_bad++; $display("FAIL l1_data[%0d]: got %h want %h", c - 1, w_out_data, exp_q[c-1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_full_simul();
    test_reset_midflight();
    test_single_reg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
